// File: rtl/regfile_multiport.sv
// ----------------------------------------------------------------------------
// regfile_multiport
//
// Register file for the EV22 datapath: one write port, N_READ independently
// addressed read ports with registered (1-cycle) reads, optional same-cycle
// write-to-read forwarding, optional hardwired zero entry, and a sequential
// clear engine that zeroes every entry one per cycle.
//
// Handshake / timing: there is no valid/ready pairing. rd_en/rd_addr and the
// write port are sampled at every rising edge; busy is high while a clear
// sweep runs, and during that time writes are dropped and enabled reads load
// 0. The first accepted write is at the edge after busy falls.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high; starts a clear sweep on release
//   rd_en      per-port read enable, bit i -> port i
//   rd_addr    port i address at [i*ADDR_W +: ADDR_W]
//   rd_data    port i data at [i*DATA_W +: DATA_W], registered
//   wr_en      write enable
//   wr_addr    write address
//   wr_data    write data
//   clr_req    one-cycle pulse, starts a clear sweep from IDLE
//   busy       high while the clear sweep is running
//   dbg_state  current FSM state encoding (0 = IDLE, 1 = CLEAR)
// ----------------------------------------------------------------------------
module regfile_multiport #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_READ-1:0]          rd_en,
    input  logic [N_READ*ADDR_W-1:0]   rd_addr,
    output logic [N_READ*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       clr_req,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int   DEPTH   = 1 << ADDR_W;
    localparam logic LP_ZERO = (ZERO_REG != 0);
    localparam logic LP_BYP  = (BYPASS != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [ADDR_W-1:0]        r_clr_ptr;
    logic [ADDR_W-1:0]        w_clr_ptr_next;
    logic                     w_busy;

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [N_READ*DATA_W-1:0] r_rd_data;
    logic [N_READ*DATA_W-1:0] w_rd_next;
    logic [ADDR_W-1:0]        w_ra;
    logic                     w_idle;
    logic                     w_wr_fire;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        w_busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_ptr_next = '0;
                end
            end
            ST_CLEAR: begin
                w_busy         = 1'b1;
                w_clr_ptr_next = r_clr_ptr + 1'b1;
                // Last entry cleared this edge; the pointer wraps to 0.
                if (r_clr_ptr == {ADDR_W{1'b1}}) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                // Unreachable encoding: recover by sweeping from scratch.
                w_busy         = 1'b1;
                w_state_next   = ST_CLEAR;
                w_clr_ptr_next = '0;
            end
        endcase
    end

    assign busy      = w_busy;
    assign dbg_state = r_state;
    assign w_idle    = (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // Storage: no reset, the sweep zeroes it. Single write port shared by
    // the sweep and the external write; the external write only in IDLE.
    // ------------------------------------------------------------------
    assign w_wr_fire = w_idle && wr_en && !(LP_ZERO && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_fire) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read lanes: zero register beats forwarding beats storage.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_next = r_rd_data;
        w_ra      = '0;
        for (int i = 0; i < N_READ; i++) begin
            w_ra = rd_addr[i*ADDR_W +: ADDR_W];
            if (rd_en[i]) begin
                if (!w_idle) begin
                    w_rd_next[i*DATA_W +: DATA_W] = '0;
                end else if (LP_ZERO && (w_ra == '0)) begin
                    w_rd_next[i*DATA_W +: DATA_W] = '0;
                end else if (LP_BYP && wr_en && (wr_addr == w_ra)) begin
                    w_rd_next[i*DATA_W +: DATA_W] = wr_data;
                end else begin
                    w_rd_next[i*DATA_W +: DATA_W] = r_mem[w_ra];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_next;
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_bp;
  logic [NR*DW-1:0] rd_data_nb;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            clr_req;
  logic            busy_bp;
  logic            busy_nb;
  logic [1:0]      dbg_bp;
  logic [1:0]      dbg_nb;

  int total = 0;
  int bad   = 0;

  // reference model: storage contents, remaining sweep edges, lane contents
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left;
  logic [DW-1:0] m_lane [2][NR];

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_bp),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
    .busy(busy_bp), .dbg_state(dbg_bp)
  );

  regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
    .busy(busy_nb), .dbg_state(dbg_nb)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_left = DEPTH;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NR; p++) m_lane[d][p] = '0;
  endtask

  // effect of the coming rising edge, from the inputs currently applied
  task automatic model_edge();
    logic [AW-1:0] a;
    if (reset) begin
      model_reset();
    end else if (m_left > 0) begin
      for (int p = 0; p < NR; p++)
        if (rd_en[p]) begin
          m_lane[0][p] = '0;
          m_lane[1][p] = '0;
        end
      m_left = m_left - 1;
    end else begin
      for (int p = 0; p < NR; p++) begin
        if (rd_en[p]) begin
          a = rd_addr[p*AW +: AW];
          for (int d = 0; d < 2; d++) begin
            if (a == 0)                                      m_lane[d][p] = '0;
            else if (d == 0 && wr_en && wr_addr == a)        m_lane[d][p] = wr_data;
            else                                             m_lane[d][p] = m_mem[a];
          end
        end
      end
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (clr_req) begin
        m_left = DEPTH;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      end
    end
  endtask

  // scoreboard comparison of both instances against the model
  task automatic check_all(input string tag);
    logic [DW-1:0] got;
    logic          exp_busy;
    exp_busy = (m_left > 0);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NR; p++) begin
        got = (d == 0) ? rd_data_bp[p*DW +: DW] : rd_data_nb[p*DW +: DW];
        total++;
        assert (got === m_lane[d][p]) else begin
          bad++;
          $error("FAIL %s dut%0d lane%0d got=%h exp=%h", tag, d, p, got, m_lane[d][p]);
        end
      end
    end
    total++;
    assert (busy_bp === exp_busy) else begin
      bad++;
      $error("FAIL %s busy_bp got=%b exp=%b", tag, busy_bp, exp_busy);
    end
    total++;
    assert (busy_nb === exp_busy) else begin
      bad++;
      $error("FAIL %s busy_nb got=%b exp=%b", tag, busy_nb, exp_busy);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NR-1:0] ren, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic clr);
    wr_en   = wen;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = ren;
    rd_addr = {a1, a0};
    clr_req = clr;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    reset = 1'b1;
    set_in(1'b0, '0, '0, '0, '0, '0, 1'b0);
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // initial sweep: exactly 32 busy edges, enabled reads return 0
    for (int c = 0; c < DEPTH; c++) begin
      set_in(1'b0, '0, '0, 2'b11, rnd_addr(), rnd_addr(), 1'b0);
      step("sweep0");
    end
    // every entry reads 0 afterwards
    for (int a = 0; a < DEPTH; a += 2) begin
      set_in(1'b0, '0, '0, 2'b11, AW'(a), AW'(a + 1), 1'b0);
      step("readall");
    end

    // plain write / read and hold
    set_in(1'b1, 5'd7, 16'hA5A5, 2'b00, '0, '0, 1'b0);  step("wr7");
    set_in(1'b1, 5'd31, 16'h1234, 2'b00, '0, '0, 1'b0); step("wr31");
    set_in(1'b0, '0, '0, 2'b11, 5'd7, 5'd31, 1'b0);      step("rd7_31");
    set_in(1'b0, '0, '0, 2'b00, 5'd3, 5'd4, 1'b0);       step("hold1");
    step("hold2");

    // forwarding: same-cycle write and read of address 9
    set_in(1'b1, 5'd9, 16'hBEEF, 2'b11, 5'd9, 5'd9, 1'b0); step("byp9");
    set_in(1'b0, '0, '0, 2'b11, 5'd9, 5'd9, 1'b0);         step("rd9");

    // zero register
    set_in(1'b1, 5'd0, 16'hFFFF, 2'b00, '0, '0, 1'b0);   step("wr0");
    set_in(1'b0, '0, '0, 2'b11, 5'd0, 5'd0, 1'b0);        step("rd0");
    set_in(1'b1, 5'd0, 16'hFFFF, 2'b11, 5'd0, 5'd0, 1'b0); step("byp0");

    // clear during use
    for (int a = 1; a <= 5; a++) begin
      set_in(1'b1, AW'(a), DW'(a * 16'h0011), 2'b00, '0, '0, 1'b0);
      step("fill");
    end
    set_in(1'b0, '0, '0, 2'b11, 5'd1, 5'd5, 1'b0);          step("rdfill");
    set_in(1'b1, 5'd6, 16'h7777, 2'b11, 5'd6, 5'd2, 1'b1);  step("clr_wr6");
    for (int c = 0; c < DEPTH; c++) begin
      if (c == 5) set_in(1'b1, 5'd3, 16'h9999, 2'b11, 5'd3, 5'd6, 1'b0);
      else        set_in(1'b0, '0, '0, 2'b11, rnd_addr(), rnd_addr(), (c == 2));
      step("sweep1");
    end
    for (int a = 1; a <= 6; a += 2) begin
      set_in(1'b0, '0, '0, 2'b11, AW'(a), AW'(a + 1), 1'b0);
      step("postclr");
    end

    // reset in the middle of a sweep
    set_in(1'b1, 5'd2, 16'h4242, 2'b11, 5'd2, 5'd2, 1'b0); step("wr2");
    set_in(1'b0, '0, '0, 2'b00, '0, '0, 1'b1);             step("clr2");
    for (int c = 0; c < 10; c++) begin
      set_in(1'b0, '0, '0, 2'b00, '0, '0, 1'b0);
      step("sweep2");
    end
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    step("rst_hold1");
    step("rst_hold2");
    reset = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      set_in(1'b0, '0, '0, NR'($urandom_range(0, 3)), rnd_addr(), rnd_addr(), 1'b0);
      step("sweep3");
    end

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 1)), rnd_addr(), DW'($urandom),
             NR'($urandom_range(0, 3)), rnd_addr(), rnd_addr(),
             ($urandom_range(0, 99) == 0));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised register file for the EV22 datapath: one write port, N_READ independently addressed read ports with one-cycle registered reads, write-to-read bypass, an optional hardwired zero register, and a sequential clear engine. It sits between instruction decode, which drives the read addresses, and writeback, which drives the write port. It replaces fixed-size, fixed-port register banks.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- N_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, if 1, entry 0 reads as 0 and writes to it are discarded
- BYPASS, 1, if 1, a same-cycle write to the address being read is forwarded to that read
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- rd_en  in  N_READ  per-port read enable; bit i controls port i
- rd_addr  in  N_READ*ADDR_W  port i address at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  N_READ*DATA_W  port i data at bits [i*DATA_W +: DATA_W], registered
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  one-cycle pulse; starts a clear sweep of all entries
- busy  out  1  high while a clear sweep is running

## Operation
- The FSM has two states, IDLE and CLEAR. A 2-bit state plus an ADDR_W-bit sweep counter, clr_ptr, implement it.
- Reset asserted: state goes to CLEAR, clr_ptr to 0, every rd_data lane to 0, and busy to 1. The storage array itself has no reset; the sweep zeroes it.
- CLEAR: each cycle writes 0 to entry clr_ptr, then increments clr_ptr.
  - When clr_ptr == DEPTH-1, the FSM goes to IDLE on the next edge, and busy falls in the same edge.
  - During CLEAR, wr_en is ignored (the write is dropped), and any enabled read port loads 0.
  - clr_req during CLEAR is ignored; it does not restart the sweep.
- IDLE:
  - clr_req=1 goes to CLEAR with clr_ptr=0 on the next edge.
  - When clr_req and wr_en are high in the same IDLE cycle, the write is performed first, then the sweep starts.
- Write (IDLE only): when wr_en=1, mem[wr_addr] <= wr_data, unless ZERO_REG=1 and wr_addr=0.
- Read (IDLE only), for each port i with rd_en[i]=1, rd_data lane i loads, in priority order:
  - 0, if ZERO_REG=1 and rd_addr_i=0;
  - wr_data, if BYPASS=1 and wr_en=1 and wr_addr=rd_addr_i (write-first);
  - mem[rd_addr_i] otherwise. With BYPASS=0 this returns the old value in a same-address collision.
- rd_en[i]=0: lane i holds its previous value.
- Ports are fully independent. Several ports may read the same address in the same cycle and all receive the same data.
- Addresses are always in range, since DEPTH = 2**ADDR_W; there is no out-of-range case.

## Timing
- Read latency is 1 cycle: address and enable sampled at edge k give data valid after edge k.
- Write latency is 1 cycle: the write lands at edge k. A read sampled at edge k+1 returns it regardless of BYPASS; the BYPASS path covers the read sampled at edge k.
- Clear sweep lasts exactly DEPTH cycles: busy is high for DEPTH edges after a clr_req edge or after reset release.
  - The first usable write is at the edge after busy falls.
- Reset asserted mid-sweep or mid-operation: immediate asynchronous return to CLEAR with clr_ptr=0, and all rd_data lanes go to 0.
- Reset deasserts synchronously to clk. The first sweep write is at the first rising edge with reset low.

## Test plan
- Reset then idle: reset pulse with DATA_W=16, ADDR_W=5 -> busy=1 for exactly 32 cycles, rd_data=0; afterwards reading every address 0..31 returns 0x0000.
- Write/read, 2 ports: write 0xA5A5 to address 7, then 0x1234 to address 31; next cycle read port0=7 and port1=31 -> one cycle later port0=0xA5A5, port1=0x1234; with rd_en=0 both lanes hold.
- Bypass: in one cycle, wr_en=1, wr_addr=9, wr_data=0xBEEF and both ports read address 9 -> both lanes are 0xBEEF the next cycle. With BYPASS=0 the same stimulus returns the old value 0x0000.
- Zero register (ZERO_REG=1): write 0xFFFF to address 0 -> a read of address 0 returns 0x0000. Same-cycle write plus read of address 0 also returns 0x0000 with BYPASS=1.
- Clear during use: fill addresses 1..5 with 0x0011..0x0055, pulse clr_req together with a write of 0x7777 to address 6, then attempt a write of 0x9999 to address 3 at cycle 5 of the sweep.
  - busy is high for 32 cycles; reads during the sweep return 0.
  - After the sweep, addresses 1..6 all read 0, and the dropped 0x9999 never appears.
- Reset mid-sweep: assert reset at sweep cycle 10 -> busy stays high, and a full 32-cycle sweep restarts from clr_ptr=0 after release.
